// File: rtl/tpu_host_driver.sv
// Host initiator for the 2x2 systolic TPU pins: loads 8 job bytes, waits for done, captures 8 result bytes (timeout via TPU_HOST_TIMEOUT_EN).
// Latency: bytes on pins T+1..T+8 after accept; result valid 8 cycles after first done.
// Backpressure: job_ready only in IDLE; RESULT holds res_* stable until res_ready.
module tpu_host_driver #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [63:0] job_data,
  input  logic        job_transpose,
  input  logic        job_relu,
  output logic [7:0]  tpu_ui_in,
  output logic [7:0]  tpu_uio_in,
  input  logic [7:0]  tpu_uo_out,
  input  logic        tpu_done,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_data,
  output logic        res_err,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_DONE, CAPTURE, RESULT} state_t;

  state_t      state, state_nxt;
  logic [63:0] job_q;
  logic [2:0]  byte_cnt;
  logic [2:0]  next_cnt;
  logic        load_en;
  logic        mode_transpose;
  logic        mode_relu;
  logic        accept;
  logic        last_byte;
  logic        to_expire;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  assign job_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign accept     = job_valid & job_ready;
  assign last_byte  = (byte_cnt == 3'd7);
  assign next_cnt   = byte_cnt + 3'd1;
  assign tpu_uio_in = {5'b00000, mode_relu, mode_transpose, load_en};

`ifdef TPU_HOST_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt;

  assign to_expire = (state == WAIT_DONE) && !tpu_done && (to_cnt == TO_LAST);

  // Counter is held at zero outside WAIT_DONE so every wait starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= 16'd0;
    end else if (state != WAIT_DONE) begin
      to_cnt <= 16'd0;
    end else if (!tpu_done) begin
      to_cnt <= to_cnt + 16'd1;
    end
  end
`else
  assign to_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = LOAD;
      LOAD:      if (last_byte) state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (tpu_done) state_nxt = CAPTURE;
        else if (to_expire) state_nxt = RESULT;
      end
      CAPTURE:   if (!tpu_done || last_byte) state_nxt = RESULT;
      RESULT:    if (res_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Pin and result registers; byte_cnt is the shown byte in LOAD, the next capture slot in CAPTURE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job_q          <= 64'd0;
      byte_cnt       <= 3'd0;
      load_en        <= 1'b0;
      mode_transpose <= 1'b0;
      mode_relu      <= 1'b0;
      tpu_ui_in      <= 8'd0;
      res_valid      <= 1'b0;
      res_err        <= 1'b0;
      res_data       <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            job_q          <= job_data;
            mode_transpose <= job_transpose;
            mode_relu      <= job_relu;
            load_en        <= 1'b1;
            tpu_ui_in      <= job_data[7:0];
            byte_cnt       <= 3'd0;
            res_data       <= 64'd0;
            res_err        <= 1'b0;
          end
        end
        LOAD: begin
          if (last_byte) begin
            load_en   <= 1'b0;
            tpu_ui_in <= 8'd0;
            byte_cnt  <= 3'd0;
          end else begin
            byte_cnt  <= next_cnt;
            tpu_ui_in <= job_q[{next_cnt, 3'b000} +: 8];
          end
        end
        WAIT_DONE: begin
          if (tpu_done) begin
            res_data[7:0] <= tpu_uo_out;
            byte_cnt      <= 3'd1;
          end else if (to_expire) begin
            res_valid <= 1'b1;
            res_err   <= 1'b1;
          end
        end
        CAPTURE: begin
          if (!tpu_done) begin
            res_valid <= 1'b1;
            res_err   <= 1'b1;
          end else begin
            res_data[{byte_cnt, 3'b000} +: 8] <= tpu_uo_out;
            byte_cnt <= next_cnt;
            if (last_byte) res_valid <= 1'b1;
          end
        end
        RESULT: begin
          if (res_ready) begin
            res_valid      <= 1'b0;
            mode_transpose <= 1'b0;
            mode_relu      <= 1'b0;
          end
        end
        default: begin
          load_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
